// File: rtl/im_loader.sv
// Streaming loader for the folded item-memory SRAM: packs IN_WIDTH-bit chunks
// into FOLD_WIDTH-bit rows and issues one active-low write per row, rows 0..NUM_ROWS-1.
module im_loader #(
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 6,
  parameter int NUM_ROWS        = 64,
  parameter int IN_WIDTH        = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [IN_WIDTH-1:0]        i_in_data,
  output logic [SRAM_ADDR_WIDTH-1:0] o_im_addr,
  output logic [FOLD_WIDTH-1:0]      o_im_din,
  output logic                       o_we,
  output logic                       o_loading,
  output logic                       o_done,
  output logic [1:0]                 o_state
);

  localparam int CHUNKS = (FOLD_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  // Handshake: a chunk transfers on a rising edge where i_in_valid && o_in_ready.
  // o_in_ready is high only in FILL; the source must hold data while it is low.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  logic [KW-1:0]              r_k;
  logic [SRAM_ADDR_WIDTH-1:0] r_row;
  logic [FOLD_WIDTH-1:0]      r_asm;
  logic                       r_in_ready;
  logic                       r_we;
  logic                       r_loading;
  logic                       r_done;

  logic                       w_hs;
  logic                       w_last_chunk;
  logic                       w_last_row;
  logic [31:0]                w_shamt;
  logic [FOLD_WIDTH-1:0]      w_data_sh;
  logic [FOLD_WIDTH-1:0]      w_mask_sh;

  // Shifting inside a FOLD_WIDTH-wide vector drops bits of the last chunk
  // that would land at or above FOLD_WIDTH.
  always_comb begin
    w_hs         = i_in_valid & r_in_ready;
    w_last_chunk = (r_k == KW'(CHUNKS - 1));
    w_last_row   = (r_row == SRAM_ADDR_WIDTH'(NUM_ROWS - 1));
    w_shamt      = 32'(r_k) * 32'(IN_WIDTH);
    w_data_sh    = FOLD_WIDTH'(i_in_data) << w_shamt;
    w_mask_sh    = FOLD_WIDTH'({IN_WIDTH{1'b1}}) << w_shamt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_row      <= '0;
      r_asm      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b1;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_FILL;
            r_k        <= '0;
            r_row      <= '0;
            r_in_ready <= 1'b1;
            r_loading  <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_hs) begin
            r_asm <= (r_asm & ~w_mask_sh) | w_data_sh;
            if (w_last_chunk) begin
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b0;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_WRITE: begin
          r_we <= 1'b1;
          if (w_last_row) begin
            r_state   <= S_DONE;
            r_loading <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state    <= S_FILL;
            r_row      <= r_row + SRAM_ADDR_WIDTH'(1);
            r_k        <= '0;
            r_in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_start) begin
            r_state    <= S_FILL;
            r_k        <= '0;
            r_row      <= '0;
            r_in_ready <= 1'b1;
            r_loading  <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_we       <= 1'b1;
          r_loading  <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_we       = r_we;
  assign o_loading  = r_loading;
  assign o_done     = r_done;
  assign o_im_addr  = r_row;
  assign o_im_din   = r_asm;
  assign o_state    = r_state;

endmodule

// File: doc/im_loader.md
# im_loader

Streaming loader that programs the folded item-memory SRAM banks through `memory_wrapper`'s write path. It accepts `IN_WIDTH`-bit chunks over a valid/ready handshake and assembles them into one `FOLD_WIDTH`-bit row. It then issues a single-cycle SRAM write per row, walking addresses 0..`NUM_ROWS`-1. It sits between the off-chip/config stream and `memory_wrapper`; while `loading` is high, the top level muxes `im_addr` and `we` from this block.

## Interface
- `FOLD_WIDTH`, 500, row width; matches `memory_wrapper` (144+144+144+68).
- `SRAM_ADDR_WIDTH`, 6, SRAM address width.
- `NUM_ROWS`, 64, rows to program; 1..2^`SRAM_ADDR_WIDTH`.
- `IN_WIDTH`, 32, input chunk width; `CHUNKS` = ceil(`FOLD_WIDTH`/`IN_WIDTH`) (16 at defaults).
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `in_valid` in 1: the chunk on `in_data` is valid.
- `in_ready` out 1: the loader accepts a chunk this cycle.
- `in_data` in `IN_WIDTH`: chunk payload.
- `im_addr` out `SRAM_ADDR_WIDTH`: SRAM row address.
- `im_din` out `FOLD_WIDTH`: SRAM write data.
- `we` out 1: active-low write strobe, driving the SRAM WEB directly; 0 means write.
- `loading` out 1: high from the cycle after `start` until DONE is entered.
- `done` out 1: high in DONE; all rows have been written.

## Operation
- States: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `in_ready`=0, `we`=1.
  - `start` → FILL; clears the row counter and the chunk counter.
- **FILL**
  - `in_ready`=1.
  - Each handshake (`in_valid`&&`in_ready`) stores `in_data` into assembly bits [k*`IN_WIDTH` +: `IN_WIDTH`], where k is the chunk counter, then increments k.
  - Bits at or above `FOLD_WIDTH` are discarded; at defaults the top 12 bits of chunk 15 are dropped.
  - A handshake with k = `CHUNKS`-1 → WRITE.
  - A cycle with `in_valid` low holds state and counters.
- **WRITE**
  - Lasts exactly one cycle: `we`=0, `im_addr`=row counter, `im_din`=assembly register, `in_ready`=0.
  - If row = `NUM_ROWS`-1 → DONE.
  - Otherwise: row+1, k cleared → FILL.
- **DONE**
  - `done`=1, `loading`=0, `we`=1, `in_ready`=0.
  - `start` → FILL with counters cleared, which reloads from row 0.
- `start` in FILL or WRITE is ignored.
- The assembly register is not cleared between rows; every bit below `FOLD_WIDTH` is overwritten each row.
- `im_addr` holds the row counter in every state; `im_din` holds the assembly register in every state.
- **Reset**
  - Any state, including mid-row → IDLE.
  - Partial row discarded; nothing is written.
  - Counters and the assembly register go to 0.
- **Reset values:** `in_ready`=0, `we`=1, `im_addr`=0, `im_din`=0, `loading`=0, `done`=0.

## Timing
- `we`, `loading`, `done` and `in_ready` decode from the state register only, so they are glitch-free with no combinational path from inputs.
- Chunk acceptance is single-cycle. The WRITE cycle immediately follows the edge that accepted the last chunk.
- The SRAM captures `im_addr`/`im_din` on the rising edge that ends the WRITE cycle.
- Throughput with `in_valid` held high: `CHUNKS`+1 cycles per row.
  - Full load = 1 (start) + `NUM_ROWS`·(`CHUNKS`+1) cycles until `done` rises: 1089 at defaults.
- `in_ready` drops for exactly one cycle per row, during WRITE. The upstream source must hold data across that cycle.
- `loading` rises the cycle after `start` is sampled. It falls in the same cycle `done` rises.

## Test plan
- **Reset values:** assert `rst` 3 cycles → all outputs at reset values; `we`=1 throughout.
- **Single row** (`NUM_ROWS`=1, `FOLD_WIDTH`=500, `IN_WIDTH`=32): `start`, then chunks 0x00000000..0x0000000F with `in_valid` held high.
  - One cycle with `we`=0, `im_addr`=0.
  - `im_din`[k*32 +: 32]=k for k<15; `im_din`[499:480]=0x0000F.
  - `done`=1 at cycle 18 after `start`.
- **Full load at defaults:** chunk value = row*16+k, continuous valid.
  - Exactly 64 `we` pulses, at addresses 0..63 in order, spaced 17 cycles apart.
  - `done` rises 1089 cycles after `start`.
- **Backpressure gaps:** `in_valid` randomly low ~50% → the same data/addresses as the gap-free run; `we` pulses only after the 16th accepted chunk.
- **Reset mid-row:** assert `rst` after chunk 7 of row 3 → no `we` pulse for row 3. A subsequent `start` rewrites from row 0 with correct data.
- **Restart and ignored start:** a `start` pulse in FILL has no effect. A `start` in DONE reloads from `im_addr`=0 and `done` falls the next cycle.
